// File: rtl/program_store.sv
// program_store: 16x10 program memory with a streamed load session that holds the CPU while loading.
// Optional checksum word after the program: define PROGSTORE_CHECKSUM_EN.
module program_store (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_start,
  input  logic [9:0] load_word,
  input  logic       load_valid,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [3:0] fetch_addr,
  output logic [9:0] fetch_data,
  output logic       cpu_hold,
  output logic [4:0] load_count,
  output logic       load_error
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
`ifdef PROGSTORE_CHECKSUM_EN
    LOAD  = 2'd1,
    CHECK = 2'd2
`else
    LOAD  = 2'd1
`endif
  } state_t;

  state_t     state_q;
  logic [4:0] waddr_q;
  logic [9:0] mem [16] = '{default: '0};

  logic accept;
  logic last_slot;
  logic sess_end;

  assign accept    = load_valid & load_ready;
  assign last_slot = (waddr_q == 5'd15);
  assign sess_end  = accept & (load_last | last_slot);

  // waddr never passes 16 in a session, so it doubles as the word count
  assign load_count = waddr_q;

`ifdef PROGSTORE_CHECKSUM_EN
  logic [9:0] csum_q;
  logic       mem_ok_q = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset && state_q == LOAD && accept)
      mem[waddr_q[3:0]] <= load_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      cpu_hold   <= 1'b0;
      load_ready <= 1'b0;
      waddr_q    <= '0;
      load_error <= 1'b0;
`ifdef PROGSTORE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_start) begin
            state_q    <= LOAD;
            cpu_hold   <= 1'b1;
            load_ready <= 1'b1;
            waddr_q    <= '0;
            load_error <= 1'b0;
`ifdef PROGSTORE_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        LOAD: begin
          if (load_start)
            load_error <= 1'b1;
          if (accept) begin
            waddr_q <= waddr_q + 5'd1;
`ifdef PROGSTORE_CHECKSUM_EN
            csum_q  <= csum_q ^ load_word;
`endif
            if (last_slot && !load_last)
              load_error <= 1'b1;
          end
          if (sess_end) begin
`ifdef PROGSTORE_CHECKSUM_EN
            state_q    <= CHECK;
`else
            state_q    <= RUN;
            cpu_hold   <= 1'b0;
            load_ready <= 1'b0;
`endif
          end
        end
`ifdef PROGSTORE_CHECKSUM_EN
        CHECK: begin
          if (load_start)
            load_error <= 1'b1;
          if (accept) begin
            state_q    <= RUN;
            cpu_hold   <= 1'b0;
            load_ready <= 1'b0;
            if (load_word == csum_q) begin
              mem_ok_q <= 1'b1;
            end else begin
              mem_ok_q   <= 1'b0;
              load_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= RUN;
          cpu_hold   <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fetch_data = '0;
`ifdef PROGSTORE_CHECKSUM_EN
    if (state_q == RUN && mem_ok_q)
`else
    if (state_q == RUN)
`endif
      fetch_data = mem[fetch_addr];
  end

endmodule
